// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI byte receiver.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_rx_state_t;

  // Zero-extension does not change parity, so one width serves every DATA_W up to 32.
  function automatic logic odd_parity(input logic [31:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/spi_byte_receiver_if.sv
// SPI pins plus received-byte outputs; master drives the pins, slave is the receiver.
interface spi_byte_receiver_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W
);

  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              parity_err;
  logic              busy;

  modport master (
    output spi_sclk, spi_mosi, spi_cs_n,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs_n,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one async pin, with registered-history rise/fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Preset to the pin's idle level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_byte_receiver.sv
// System-clocked SPI mode-0 slave receiver, MSB first, framed by cs_n.
// Optional odd-parity bit per frame enabled by defining SPI_RX_PARITY_EN.
module spi_byte_receiver import spi_pkg::*; #(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_byte_receiver_if.slave bus
);

`ifdef SPI_RX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  // The last frame bit is never stored; it is combined directly at completion.
  localparam int               SHIFT_W  = FRAME_LEN - 1;
  localparam int               CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_rx_state_t     state, state_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [SHIFT_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] rx_data_q, rx_data_next;
  logic              rx_valid_q, rx_valid_next;
  logic              frame_err_q, frame_err_next;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .raw(bus.spi_sclk),
    .sync(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .raw(bus.spi_cs_n),
    .sync(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .raw(bus.spi_mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

`ifdef SPI_RX_PARITY_EN
  logic parity_err_q, parity_err_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shift_reg   <= shift_next;
      rx_data_q   <= rx_data_next;
      rx_valid_q  <= rx_valid_next;
      frame_err_q <= frame_err_next;
    end
  end

  // cs_rise outranks a coincident sclk_rise, so that bit is dropped.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_q;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
`ifdef SPI_RX_PARITY_EN
    parity_err_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next     = IDLE;
          frame_err_next = (bit_cnt != '0);
          bit_cnt_next   = '0;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[SHIFT_W-2:0], mosi_sync};
          if (bit_cnt == LAST_CNT) begin
            bit_cnt_next = '0;
`ifdef SPI_RX_PARITY_EN
            if (mosi_sync == odd_parity(32'(shift_reg))) begin
              rx_data_next  = shift_reg;
              rx_valid_next = 1'b1;
            end else begin
              parity_err_next = 1'b1;
            end
`else
            rx_data_next  = {shift_reg, mosi_sync};
            rx_valid_next = 1'b1;
`endif
          end else begin
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SPI_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_next;
  end
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Scoreboard bench for spi_byte_receiver; also covers the SPI_RX_PARITY_EN build.
module tb_spi_byte_receiver;
  import spi_pkg::*;

  localparam int DATA_W = SPI_DATA_W;
  localparam int HALF   = 40;

  logic clk = 1'b0;
  logic rst_n;

  spi_byte_receiver_if #(.DATA_W(DATA_W)) bus ();

  spi_byte_receiver #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int frame_cnt = 0;
  int parity_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_d;

  // Scoreboard pops on every rx_valid; pulses with nothing queued are failures.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.frame_err === 1'b1) frame_cnt++;
      if (bus.parity_err === 1'b1) parity_cnt++;
      if (bus.rx_valid === 1'b1) begin
        valid_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_rx_valid: got rx_data=%0h, required no pulse", bus.rx_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (bus.rx_data !== exp_d) begin
            bad++;
            $display("[TB] FAIL rx_data: got %0h, required %0h", bus.rx_data, exp_d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_bit(input logic b);
    bus.spi_mosi = b;
    #HALF;
    bus.spi_sclk = 1'b1;
    #HALF;
    bus.spi_sclk = 1'b0;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    bus.spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_byte(input logic [DATA_W-1:0] d);
    exp_q.push_back(d);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i]);
`ifdef SPI_RX_PARITY_EN
    send_bit(~^d);
`endif
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: got %0d bytes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    total += 5;
    if (bus.rx_data !== '0) begin bad++; $display("[TB] FAIL reset_rx_data: got %0h, required 0", bus.rx_data); end
    if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_valid: got %b, required 0", bus.rx_valid); end
    if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err: got %b, required 0", bus.frame_err); end
    if (bus.parity_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_parity_err: got %b, required 0", bus.parity_err); end
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int v0 = valid_cnt;
    int f0 = frame_cnt;
    cs_low();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_high: got %b, required 1", bus.busy); end
    send_byte(8'hA5);
    cs_high();
    drain("single");
    total += 3;
    if (valid_cnt - v0 !== 1) begin bad++; $display("[TB] FAIL single_valid_count: got %0d, required 1", valid_cnt - v0); end
    if (frame_cnt !== f0) begin bad++; $display("[TB] FAIL single_frame_err: got %0d pulses, required 0", frame_cnt - f0); end
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_low: got %b, required 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    cs_low();
    send_byte(8'h12);
    send_byte(8'hFF);
    cs_high();
    drain("b2b");
    total += 2;
    if (valid_cnt - v0 !== 2) begin bad++; $display("[TB] FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0); end
    if (bus.rx_data !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_final_data: got %0h, required ff", bus.rx_data); end
  endtask

  task automatic test_frame_err();
    logic [7:0] part = 8'h3C;
    int v0 = valid_cnt;
    int f0 = frame_cnt;
    cs_low();
    for (int i = 7; i >= 3; i--) send_bit(part[i]);
    cs_high();
    total += 3;
    if (frame_cnt - f0 !== 1) begin bad++; $display("[TB] FAIL frame_err_count: got %0d, required 1", frame_cnt - f0); end
    if (valid_cnt !== v0) begin bad++; $display("[TB] FAIL frame_err_valid: got %0d pulses, required 0", valid_cnt - v0); end
    if (bus.rx_data !== 8'hFF) begin bad++; $display("[TB] FAIL frame_err_hold: got %0h, required ff", bus.rx_data); end
    cs_low();
    send_byte(8'h07);
    cs_high();
    drain("after_frame_err");
    total++;
    if (frame_cnt - f0 !== 1) begin bad++; $display("[TB] FAIL frame_err_recover: got %0d pulses, required 1", frame_cnt - f0); end
  endtask

  task automatic test_idle_sclk();
    int v0 = valid_cnt;
    int f0 = frame_cnt;
    int busy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      bus.spi_mosi = 1'($urandom_range(1, 0));
      bus.spi_sclk = 1'b1;
      repeat (4) begin @(negedge clk); if (bus.busy !== 1'b0) busy_seen++; end
      bus.spi_sclk = 1'b0;
      repeat (4) begin @(negedge clk); if (bus.busy !== 1'b0) busy_seen++; end
    end
    total += 4;
    if (busy_seen !== 0) begin bad++; $display("[TB] FAIL idle_busy: got %0d busy cycles, required 0", busy_seen); end
    if (valid_cnt !== v0) begin bad++; $display("[TB] FAIL idle_valid: got %0d pulses, required 0", valid_cnt - v0); end
    if (frame_cnt !== f0) begin bad++; $display("[TB] FAIL idle_frame_err: got %0d pulses, required 0", frame_cnt - f0); end
    if (bus.rx_data !== 8'h07) begin bad++; $display("[TB] FAIL idle_hold: got %0h, required 07", bus.rx_data); end
  endtask

  task automatic test_reset_midframe();
    cs_low();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL midframe_busy: got %b, required 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total += 3;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_busy: got %b, required 0", bus.busy); end
    if (bus.rx_data !== '0) begin bad++; $display("[TB] FAIL async_reset_data: got %0h, required 0", bus.rx_data); end
    if (bus.rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_valid: got %b, required 0", bus.rx_valid); end
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_busy: got %b, required 0", bus.busy); end
    cs_low();
    send_byte(8'h81);
    cs_high();
    drain("after_reset");
  endtask

`ifdef SPI_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d = 8'h55;
    int v0 = valid_cnt;
    int p0 = parity_cnt;
    exp_q.push_back(d);
    cs_low();
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b1);
    cs_high();
    drain("parity_good");
    cs_low();
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b0);
    cs_high();
    total += 3;
    if (parity_cnt - p0 !== 1) begin bad++; $display("[TB] FAIL parity_err_count: got %0d, required 1", parity_cnt - p0); end
    if (valid_cnt - v0 !== 1) begin bad++; $display("[TB] FAIL parity_valid_count: got %0d, required 1", valid_cnt - v0); end
    if (bus.rx_data !== 8'h55) begin bad++; $display("[TB] FAIL parity_hold: got %0h, required 55", bus.rx_data); end
  endtask
`else
  task automatic test_parity();
    total++;
    if (parity_cnt !== 0) begin bad++; $display("[TB] FAIL parity_tied_low: got %0d pulses, required 0", parity_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_err();
    test_idle_sclk();
    test_reset_midframe();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
